// File: rtl/logical_left_shift_seq_if.sv
// Operand/result bundle between the ALU control unit and the sequential left shifter.
// Latency: none (wires only); timing is owned by the shifter.
// Backpressure: none; the master must not expect a start to be queued while busy is high.
//
// Signals: start/unshifted/shiftBy (master -> shifter), shifted/busy/done (shifter -> master).
// Build option SHL_ROTATE_EN adds the 1-bit rotate request (master -> shifter).
interface logical_left_shift_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] unshifted;
    logic [WIDTH-1:0] shiftBy;
    logic [WIDTH-1:0] shifted;
    logic             busy;
    logic             done;
`ifdef SHL_ROTATE_EN
    logic             rotate;

    modport master (
        output start, unshifted, shiftBy, rotate,
        input  shifted, busy, done
    );
    modport slave (
        input  start, unshifted, shiftBy, rotate,
        output shifted, busy, done
    );
`else
    modport master (
        output start, unshifted, shiftBy,
        input  shifted, busy, done
    );
    modport slave (
        input  start, unshifted, shiftBy,
        output shifted, busy, done
    );
`endif
endinterface

// File: rtl/logical_left_shift_seq.sv
// Multi-cycle logical left shifter: one bit position per clock, no long combinational path.
// Latency: shift amount N gives done in the cycle after accept edge + N + 1 (N=0 -> 1 cycle).
// Backpressure: start is ignored (not queued) while busy; a start during the done cycle is accepted.
//
// Ports: clk (rising edge), clr_n (async active-low reset), bus (slave side of
// logical_left_shift_seq_if: start/unshifted/shiftBy in, shifted/busy/done out).
// Build option SHL_ROTATE_EN: adds bus.rotate, latched on accept; when set, the MSB
// wraps into the LSB on each step instead of shifting in a zero.
module logical_left_shift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                      clk,
    input  logic                      clr_n,
    logical_left_shift_seq_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

    logic [1:0]         state_q,   state_d;
    logic [SHAMT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0]   shifted_q, shifted_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               fill_bit;

    // Amounts are taken modulo WIDTH; the upper bits are deliberately dropped.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^bus.shiftBy[WIDTH-1:SHAMT_W];

`ifdef SHL_ROTATE_EN
    logic rotate_q, rotate_d;
    assign fill_bit = rotate_q ? shifted_q[WIDTH-1] : 1'b0;
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shifted_d = shifted_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef SHL_ROTATE_EN
        rotate_d  = rotate_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (count_q != '0) begin
                    shifted_d = {shifted_q[WIDTH-2:0], fill_bit};
                    count_d   = count_q - CNT_ONE;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise,
                // so done is a single-cycle pulse and back-to-back ops need no bubble.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                if (bus.start) begin
                    state_d   = ST_SHIFT;
                    shifted_d = bus.unshifted;
                    count_d   = bus.shiftBy[SHAMT_W-1:0];
                    busy_d    = 1'b1;
`ifdef SHL_ROTATE_EN
                    rotate_d  = bus.rotate;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shifted_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHL_ROTATE_EN
            rotate_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shifted_q <= shifted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SHL_ROTATE_EN
            rotate_q  <= rotate_d;
`endif
        end
    end

    assign bus.shifted = shifted_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_logical_left_shift_seq.sv
// Directed-vector bench for the sequential left shifter.
// Latency: checks done timing relative to the accepting edge.
// Backpressure: checks that start while busy is ignored and start during done is accepted.
module tb_logical_left_shift_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    logical_left_shift_seq_if #(.WIDTH(W)) ifc ();

    logical_left_shift_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (ifc.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse; returns #1 after the accepting edge. Inputs are
    // scrambled afterwards to show they are not sampled again.
    task automatic launch(input logic [W-1:0] op, input logic [W-1:0] amt);
        ifc.start     = 1'b1;
        ifc.unshifted = op;
        ifc.shiftBy   = amt;
        step();
        ifc.start     = 1'b0;
        ifc.unshifted = 32'h5A5A_C3C3;
        ifc.shiftBy   = 32'h0000_0007;
    endtask

    // Counts edges after the accept until done (k) and cycles seen busy.
    task automatic wait_done(output int k, output int busy_cnt);
        k = 0;
        busy_cnt = 0;
        while (ifc.done !== 1'b1 && k < 40) begin
            if (ifc.busy === 1'b1) busy_cnt++;
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        clr_n         = 1'b0;
        ifc.start     = 1'b0;
        ifc.unshifted = '0;
        ifc.shiftBy   = '0;
`ifdef SHL_ROTATE_EN
        ifc.rotate    = 1'b0;
`endif
        #1;
        n_cmp++; if (ifc.shifted !== 32'h0) begin n_bad++; $display("FAIL reset_shifted got %h want 00000000", ifc.shifted); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", ifc.done); end
        step();
        step();
        clr_n = 1'b1;
        step();
        n_cmp++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got busy=%b done=%b want 0/0", ifc.busy, ifc.done); end
    endtask

    task automatic test_basic();
        int k, bc;
        launch(32'h0000_0001, 32'd4);
        wait_done(k, bc);
        n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", k); end
        n_cmp++; if (bc !== 5) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
        n_cmp++; if (ifc.shifted !== 32'h0000_0010) begin n_bad++; $display("FAIL basic_result got %h want 00000010", ifc.shifted); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", ifc.busy); end
        step();
        n_cmp++; if (ifc.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", ifc.done); end
        step();
        step();
        n_cmp++; if (ifc.shifted !== 32'h0000_0010) begin n_bad++; $display("FAIL basic_hold got %h want 00000010", ifc.shifted); end
    endtask

    task automatic test_amount_wrap();
        int k, bc;
        launch(32'hDEAD_BEEF, 32'd0);
        wait_done(k, bc);
        n_cmp++; if (k !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", k); end
        n_cmp++; if (ifc.shifted !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL zero_result got %h want deadbeef", ifc.shifted); end
        launch(32'h8000_0003, 32'h0000_0021);
        wait_done(k, bc);
        n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL wrap33_latency got %0d want 2", k); end
        n_cmp++; if (ifc.shifted !== 32'h0000_0006) begin n_bad++; $display("FAIL wrap33_result got %h want 00000006", ifc.shifted); end
        step();
        launch(32'h0000_00F0, 32'h0000_0020);
        wait_done(k, bc);
        n_cmp++; if (k !== 1 || ifc.shifted !== 32'h0000_00F0) begin n_bad++; $display("FAIL wrap32 got k=%0d %h want k=1 000000f0", k, ifc.shifted); end
    endtask

    task automatic test_max_and_ignored_start();
        int k;
        launch(32'hFFFF_FFFF, 32'd31);
        k = 0;
        while (ifc.done !== 1'b1 && k < 40) begin
            if (k == 5) begin
                ifc.start     = 1'b1;
                ifc.unshifted = 32'h0000_1234;
                ifc.shiftBy   = 32'd2;
            end else begin
                ifc.start = 1'b0;
            end
            step();
            k++;
        end
        ifc.start = 1'b0;
        n_cmp++; if (k !== 32) begin n_bad++; $display("FAIL max_latency got %0d want 32", k); end
        n_cmp++; if (ifc.shifted !== 32'h8000_0000) begin n_bad++; $display("FAIL max_result got %h want 80000000", ifc.shifted); end
        step();
        n_cmp++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin n_bad++; $display("FAIL ignored_start_idle got busy=%b done=%b want 0/0", ifc.busy, ifc.done); end
        step();
        step();
        n_cmp++; if (ifc.shifted !== 32'h8000_0000 || ifc.busy !== 1'b0) begin n_bad++; $display("FAIL ignored_start_hold got %h busy=%b want 80000000 0", ifc.shifted, ifc.busy); end
    endtask

    task automatic test_back_to_back();
        int k, bc;
        ifc.start     = 1'b1;
        ifc.unshifted = 32'h0000_0005;
        ifc.shiftBy   = 32'd2;
        step();
        // start stays high; the next operand waits to be taken at DONE.
        ifc.unshifted = 32'h0000_0003;
        ifc.shiftBy   = 32'd3;
        wait_done(k, bc);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 3", k); end
        n_cmp++; if (ifc.shifted !== 32'h0000_0014) begin n_bad++; $display("FAIL b2b_first_result got %h want 00000014", ifc.shifted); end
        step();
        ifc.start = 1'b0;
        n_cmp++; if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin n_bad++; $display("FAIL b2b_no_bubble got busy=%b done=%b want 1/0", ifc.busy, ifc.done); end
        wait_done(k, bc);
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 4", k); end
        n_cmp++; if (ifc.shifted !== 32'h0000_0018) begin n_bad++; $display("FAIL b2b_second_result got %h want 00000018", ifc.shifted); end
        step();
    endtask

    task automatic test_mid_reset();
        int done_seen;
        int busy_seen;
        launch(32'h0000_00FF, 32'd10);
        step();
        step();
        step();
        n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", ifc.busy); end
        #2;
        clr_n = 1'b0;
        #1;
        n_cmp++; if (ifc.shifted !== 32'h0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin n_bad++; $display("FAIL midrst_async got %h busy=%b done=%b want 0 0 0", ifc.shifted, ifc.busy, ifc.done); end
        step();
        clr_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (ifc.done === 1'b1) done_seen++;
            if (ifc.busy === 1'b1) busy_seen++;
            step();
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", done_seen); end
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL midrst_no_busy got %0d cycles want 0", busy_seen); end
        n_cmp++; if (ifc.shifted !== 32'h0) begin n_bad++; $display("FAIL midrst_shifted got %h want 00000000", ifc.shifted); end
    endtask

`ifdef SHL_ROTATE_EN
    task automatic test_rotate();
        int k, bc;
        ifc.rotate = 1'b1;
        launch(32'h8000_0001, 32'd1);
        ifc.rotate = 1'b0;
        wait_done(k, bc);
        n_cmp++; if (ifc.shifted !== 32'h0000_0003) begin n_bad++; $display("FAIL rotate_result got %h want 00000003", ifc.shifted); end
        launch(32'h8000_0001, 32'd1);
        wait_done(k, bc);
        n_cmp++; if (ifc.shifted !== 32'h0000_0002) begin n_bad++; $display("FAIL norotate_result got %h want 00000002", ifc.shifted); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_amount_wrap();
        test_max_and_ignored_start();
        test_back_to_back();
        test_mid_reset();
`ifdef SHL_ROTATE_EN
        test_rotate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
